// File: rtl/sl_preceptron_job_ctrl.sv
// Job sequencer in front of sl_preceptron_top: optional 64-weight SRAM reload,
// threshold programming, 4-lane data streaming and MAC-done/timeout result capture.
module sl_preceptron_job_ctrl #(
    parameter int                          DATA_IN_LANES     = 4,
    parameter int                          DATA_IN_WIDTH     = 8,
    parameter int                          MEM_ADDR_WIDTH    = 16,
    parameter int                          WEIGHTS_WIDTH     = 8,
    parameter int                          VECTOR_LENGTH     = 64,
    parameter int                          SUM_WIDTH         = DATA_IN_WIDTH + WEIGHTS_WIDTH + $clog2(VECTOR_LENGTH),
    parameter logic [MEM_ADDR_WIDTH-1:0]   SRAM_BASE_ADDRESS = 'h1000,
    parameter int                          DONE_TIMEOUT      = 64
) (
    input  logic                                   clk,
    input  logic                                   reset_done,
    input  logic                                   job_valid,
    output logic                                   job_ready,
    input  logic [SUM_WIDTH-1:0]                   job_threshold,
    input  logic                                   job_reload,
    input  logic                                   w_valid,
    output logic                                   w_ready,
    input  logic [WEIGHTS_WIDTH-1:0]               w_data,
    input  logic                                   x_valid,
    output logic                                   x_ready,
    input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] x_data,
    output logic                                   mem_wen,
    output logic                                   mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
    output logic [WEIGHTS_WIDTH-1:0]               mem_wdata,
    output logic                                   data_valid,
    output logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] data_in,
    output logic [SUM_WIDTH-1:0]                   cfg_ai_threshold,
    input  logic [SUM_WIDTH-1:0]                   status_ai_sum,
    input  logic                                   status_ai_comparator,
    input  logic                                   mac_done,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [SUM_WIDTH-1:0]                   res_sum,
    output logic                                   res_comp,
    output logic                                   res_timeout,
    output logic                                   busy
);

    localparam int NUM_BEATS = VECTOR_LENGTH / DATA_IN_LANES;
    localparam int WIDX_W    = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int TO_W      = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        CFG,
        STREAM,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              weights_loaded;
    logic [WIDX_W-1:0] widx;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TO_W-1:0]   tcnt;

    logic job_hs;
    logic w_hs;
    logic x_hs;
    logic last_w;
    logic last_beat;
    logic to_expire;

    assign job_hs    = job_valid && job_ready;
    assign w_hs      = w_valid && w_ready;
    assign x_hs      = x_valid && x_ready;
    assign last_w    = (widx == WIDX_W'(VECTOR_LENGTH - 1));
    assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));
    assign to_expire = (tcnt == TO_W'(DONE_TIMEOUT - 1));
    assign busy      = (state != IDLE);
    assign mem_ren   = 1'b0;

    always_ff @(posedge clk or posedge reset_done) begin
        if (reset_done) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        w_ready   = 1'b0;
        x_ready   = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                job_ready = !reset_done;
                if (job_valid && !reset_done) begin
                    state_nxt = (job_reload || !weights_loaded) ? LOAD_W : CFG;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && last_w) begin
                    state_nxt = CFG;
                end
            end
            CFG: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                x_ready = 1'b1;
                if (x_valid && last_beat) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // mac_done wins over an expiring timeout in the same cycle.
                if (mac_done || to_expire) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset_done) begin
        if (reset_done) begin
            weights_loaded   <= 1'b0;
            widx             <= '0;
            beat_cnt         <= '0;
            tcnt             <= '0;
            cfg_ai_threshold <= '0;
            mem_wen          <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            data_valid       <= 1'b0;
            data_in          <= '0;
            res_sum          <= '0;
            res_comp         <= 1'b0;
            res_timeout      <= 1'b0;
        end else begin
            mem_wen    <= w_hs;
            data_valid <= x_hs;

            if (job_hs) begin
                cfg_ai_threshold <= job_threshold;
                widx             <= '0;
                beat_cnt         <= '0;
            end

            if (w_hs) begin
                mem_addr  <= SRAM_BASE_ADDRESS + MEM_ADDR_WIDTH'(widx);
                mem_wdata <= w_data;
                widx      <= widx + WIDX_W'(1);
                if (last_w) begin
                    weights_loaded <= 1'b1;
                end
            end

            if (x_hs) begin
                data_in  <= x_data;
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end

            // tcnt is held at zero outside WAIT_DONE, so it is cleared on entry.
            if (state == WAIT_DONE) begin
                tcnt <= tcnt + TO_W'(1);
                if (mac_done) begin
                    res_sum     <= status_ai_sum;
                    res_comp    <= status_ai_comparator;
                    res_timeout <= 1'b0;
                end else if (to_expire) begin
                    res_sum        <= '0;
                    res_comp       <= 1'b0;
                    res_timeout    <= 1'b1;
                    weights_loaded <= 1'b0;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sl_preceptron_job_ctrl.sv
// Randomized bench for sl_preceptron_job_ctrl: a job-level reference model fills
// expectation queues; an independent monitor pops and compares DUT outputs.
module tb_sl_preceptron_job_ctrl;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int WW    = 8;
    localparam int VL    = 64;
    localparam int SW    = 22;
    localparam int BASE  = 'h1000;
    localparam int TO    = 64;
    localparam int NB    = VL / LANES;
    localparam int XW    = LANES * DW;

    logic          clk = 1'b0;
    logic          reset_done;
    logic          job_valid, job_ready, job_reload;
    logic [SW-1:0] job_threshold;
    logic          w_valid, w_ready;
    logic [WW-1:0] w_data;
    logic          x_valid, x_ready;
    logic [XW-1:0] x_data;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          data_valid;
    logic [XW-1:0] data_in;
    logic [SW-1:0] cfg_ai_threshold;
    logic [SW-1:0] status_ai_sum;
    logic          status_ai_comparator, mac_done;
    logic          res_valid, res_ready;
    logic [SW-1:0] res_sum;
    logic          res_comp, res_timeout, busy;

    sl_preceptron_job_ctrl dut (
        .clk                  (clk),
        .reset_done           (reset_done),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .job_threshold        (job_threshold),
        .job_reload           (job_reload),
        .w_valid              (w_valid),
        .w_ready              (w_ready),
        .w_data               (w_data),
        .x_valid              (x_valid),
        .x_ready              (x_ready),
        .x_data               (x_data),
        .mem_wen              (mem_wen),
        .mem_ren              (mem_ren),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .data_valid           (data_valid),
        .data_in              (data_in),
        .cfg_ai_threshold     (cfg_ai_threshold),
        .status_ai_sum        (status_ai_sum),
        .status_ai_comparator (status_ai_comparator),
        .mac_done             (mac_done),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_sum              (res_sum),
        .res_comp             (res_comp),
        .res_timeout          (res_timeout),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [WW-1:0] data; } wr_t;
    typedef struct packed { logic [XW-1:0] data; logic [SW-1:0] thr; } bt_t;
    typedef struct packed { logic [SW-1:0] sum; logic comp; logic to; } rs_t;

    wr_t wq[$];
    bt_t bq[$];
    rs_t rq[$];

    int  vectors = 0;
    int  errors  = 0;
    bit  model_loaded = 1'b0;

    wr_t           mon_w;
    bt_t           mon_b;
    logic [XW-1:0] last_x = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic pat(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 2) == 0;
            default: return ($urandom % 4) != 0;
        endcase
    endfunction

    // Monitor: samples 1 time unit after the falling edge, after the driver has settled.
    always begin
        @(negedge clk);
        #1;
        if (reset_done) begin
            last_x = '0;
        end else begin
            if (mem_wen) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", mem_wen, 1'b0);
                end else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", mem_addr, mon_w.addr);
                    check("wr_data", mem_wdata, mon_w.data);
                end
            end
            if (data_valid) begin
                if (bq.size() == 0) begin
                    check("unexpected_beat", data_valid, 1'b0);
                end else begin
                    mon_b = bq.pop_front();
                    check("beat_data", data_in, mon_b.data);
                    check("beat_threshold", cfg_ai_threshold, mon_b.thr);
                    last_x = mon_b.data;
                end
            end else begin
                check("data_in_hold", data_in, last_x);
            end
            if (res_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_result", res_valid, 1'b0);
                end else begin
                    check("res_sum", res_sum, rq[0].sum);
                    check("res_comp", res_comp, rq[0].comp);
                    check("res_timeout", res_timeout, rq[0].to);
                    if (res_ready) void'(rq.pop_front());
                end
            end
        end
    end

    task automatic idle_inputs();
        job_valid = 1'b0; job_reload = 1'b0; job_threshold = '0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
        mac_done = 1'b0; status_ai_sum = '0; status_ai_comparator = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic reset_mid_job();
        #2;
        reset_done = 1'b1;
        #1;
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_job_ready", job_ready, 1'b0);
        idle_inputs();
        wq.delete();
        bq.delete();
        rq.delete();
        model_loaded = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_done = 1'b0;
        @(negedge clk);
    endtask

    // d < 0 means mac_done never arrives; rst_at >= 0 resets after that many weight writes.
    task automatic run_job(input logic [SW-1:0] thr, input bit reload, input int wmode,
                           input int xmode, input int d, input bit index_w,
                           input logic [SW-1:0] sum, input bit comp, input int rdly,
                           input int rst_at);
        logic [WW-1:0] w[VL];
        logic [XW-1:0] x[NB];
        bit            do_load;
        int            wi, xi, n;

        for (int i = 0; i < VL; i++) w[i] = index_w ? WW'(i) : WW'($urandom);
        for (int i = 0; i < NB; i++) x[i] = XW'($urandom);
        do_load = reload || !model_loaded;
        if (do_load)
            for (int i = 0; i < VL; i++) wq.push_back('{addr: AW'(BASE + i), data: w[i]});
        for (int i = 0; i < NB; i++) bq.push_back('{data: x[i], thr: thr});
        if (d >= 0) rq.push_back('{sum: sum, comp: comp, to: 1'b0});
        else        rq.push_back('{sum: '0, comp: 1'b0, to: 1'b1});

        check("job_ready_idle", job_ready, 1'b1);
        job_valid = 1'b1; job_threshold = thr; job_reload = reload;
        @(negedge clk);
        job_valid = 1'b0; job_threshold = SW'($urandom); job_reload = 1'($urandom);
        check("busy_after_accept", busy, 1'b1);

        if (do_load) begin
            wi = 0; n = 0;
            while (wi < VL && n < 20 * VL) begin
                w_valid = pat(wmode, n);
                w_data  = w[wi];
                if (w_valid && w_ready) wi++;
                @(negedge clk);
                n++;
                if (wi == rst_at) begin
                    reset_mid_job();
                    return;
                end
            end
            w_valid = 1'b0;
            check("weights_accepted", wi, VL);
            model_loaded = 1'b1;
        end

        // CFG for exactly one cycle, then STREAM; stray x_valid here must be ignored.
        check("cfg_x_ready_low", x_ready, 1'b0);
        x_valid = 1'($urandom); x_data = XW'($urandom);
        @(negedge clk);
        check("stream_x_ready", x_ready, 1'b1);

        xi = 0; n = 0;
        while (xi < NB && n < 20 * NB) begin
            x_valid = pat(xmode, n);
            x_data  = x[xi];
            w_valid = 1'($urandom); w_data = WW'($urandom);
            mac_done = ($urandom % 3) == 0;
            status_ai_sum = SW'($urandom);
            if (x_valid && x_ready) xi++;
            @(negedge clk);
            n++;
        end
        x_valid = 1'b0; w_valid = 1'b0; mac_done = 1'b0;
        check("beats_accepted", xi, NB);
        check("wait_x_ready_low", x_ready, 1'b0);

        if (d >= 0) begin
            for (int i = 0; i < d; i++) begin
                x_valid = 1'($urandom);
                status_ai_sum = SW'($urandom); status_ai_comparator = 1'($urandom);
                @(negedge clk);
            end
            check("no_res_before_done", res_valid, 1'b0);
            x_valid = 1'b0;
            mac_done = 1'b1; status_ai_sum = sum; status_ai_comparator = comp;
            @(negedge clk);
            mac_done = 1'b0; status_ai_sum = ~sum; status_ai_comparator = !comp;
            check("res_valid_after_done", res_valid, 1'b1);
        end else begin
            n = 0;
            while (!res_valid && n < 4 * TO) begin
                x_valid = 1'($urandom);
                status_ai_sum = SW'($urandom); status_ai_comparator = 1'($urandom);
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, TO);
            model_loaded = 1'b0;
        end
        x_valid = 1'b0;

        for (int i = 0; i < rdly; i++) begin
            mac_done = ($urandom % 2) == 0;
            @(negedge clk);
        end
        mac_done = 1'b0;
        check("res_valid_held", res_valid, 1'b1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 1'b0);
        check("job_ready_back", job_ready, 1'b1);
        check("writes_outstanding", wq.size(), 0);
        check("beats_outstanding", bq.size(), 0);
        check("results_outstanding", rq.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_done = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset_ctrl", {mem_wen, mem_ren, data_valid, res_valid, res_comp, res_timeout,
                             busy, w_ready, x_ready, job_ready}, '0);
        check("reset_mem", {mem_addr, mem_wdata}, '0);
        check("reset_data_in", data_in, '0);
        check("reset_threshold", cfg_ai_threshold, '0);
        check("reset_res_sum", res_sum, '0);
        reset_done = 1'b0;
        @(negedge clk);
        check("idle_job_ready", job_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // First job: index weights, back-to-back streams.
        run_job(SW'(1000), 1'b0, 0, 0, 3, 1'b1, SW'(1234), 1'b1, 0, -1);
        // Second job: weights retained, no writes expected.
        run_job(SW'(5), 1'b0, 0, 0, 0, 1'b0, SW'($urandom), 1'($urandom), 0, -1);
        // Backpressure on both streams and on the result port.
        run_job(SW'($urandom), 1'b1, 1, 1, 5, 1'b0, SW'($urandom), 1'($urandom), 10, -1);
        // Timeout, then a reload=0 job that must reload.
        run_job(SW'($urandom), 1'b0, 0, 0, -1, 1'b0, '0, 1'b0, 3, -1);
        run_job(SW'($urandom), 1'b0, 2, 2, 10, 1'b0, SW'($urandom), 1'($urandom), 2, -1);
        // Reset at the 30th weight write, then a full reload.
        run_job(SW'($urandom), 1'b1, 0, 0, 0, 1'b0, '0, 1'b0, 0, 30);
        run_job(SW'($urandom), 1'b0, 0, 0, TO - 1, 1'b0, SW'($urandom), 1'($urandom), 1, -1);

        for (int j = 0; j < 14; j++) begin
            run_job(SW'($urandom), ($urandom % 4) == 0, $urandom_range(0, 2), $urandom_range(0, 2),
                    (($urandom % 6) == 0) ? -1 : int'($urandom_range(0, TO - 1)), 1'b0,
                    SW'($urandom), 1'($urandom), $urandom_range(0, 5), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
